tc_fetch_unit: RTL and testbench
================================

TC_FETCH_UNIT -- requirements
Module: tc_fetch_unit

Interface
REQ-001 Parameter WORD_WIDTH, default 16, SHALL set the width of each program word; legal value is any width of at least 16.
REQ-002 Parameter RESET_PC, default 16'h0000, SHALL set the PC loaded at reset.
REQ-003 Parameter HALT_WORD, default 16'hFFFF, SHALL set the instruction word-0 value that halts fetch; it is compared with word 0 bits [15:0].
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-low reset (0 = reset).
REQ-006 prog_addr  out  16  SHALL be the address driven to the program memory, equal to the current PC.
REQ-007 prog_w0..prog_w3  in  WORD_WIDTH each  SHALL be the program-memory words at prog_addr+0..+3, combinational, same cycle.
REQ-008 redirect_valid  in  1  SHALL request a PC change (branch or jump).
REQ-009 redirect_pc  in  16  SHALL be the target PC, sampled when redirect_valid=1.
REQ-010 instr_valid  out  1  SHALL indicate that an instruction is held for decode.
REQ-011 instr_ready  in  1  SHALL mean that decode accepts the instruction this cycle.
REQ-012 instr_w0..instr_w3  out  WORD_WIDTH each  SHALL be the held instruction words.
REQ-013 instr_len  out  3  SHALL be the held instruction length in words, from 1 to 4.
REQ-014 instr_pc  out  16  SHALL be the address of instr_w0.
REQ-015 halted  out  1  SHALL be high while in state HALTED.
REQ-016 fetch_count  out  32  SHALL count the instructions accepted by decode.

Function
REQ-017 The instruction length SHALL be prog_w0[15:14]+1, giving 1 to 4 words.
REQ-018 The FSM SHALL have exactly two states, RUN and HALTED.
REQ-019 A transfer SHALL occur when instr_valid=1 and instr_ready=1.
REQ-020 Load condition: in RUN, with redirect_valid=0, when instr_valid=0 or a transfer occurs, the block SHALL on that edge:
- capture prog_w0..3, the length, and the PC into the output registers;
- set instr_valid=1;
- set PC = PC + len, modulo 2^16.
REQ-021 When instr_valid=1 and instr_ready=0, the outputs and PC SHALL stay stable (no overwrite).
REQ-022 Throughput SHALL be one instruction per cycle while instr_ready=1, with one cycle of latency from PC to instr_valid.
REQ-023 When a loaded prog_w0[15:0] equals HALT_WORD, the block SHALL present that instruction normally and enter HALTED on the same edge; it SHALL not load again until redirect.
REQ-024 redirect_valid=1 SHALL have the highest priority and, on the edge, SHALL:
- set PC = redirect_pc;
- clear instr_valid;
- force RUN.
Loading SHALL resume the following cycle.
REQ-025 If redirect_valid=1 and a transfer occur in the same cycle, the transfer SHALL count (fetch_count increments), then the flush applies.
REQ-026 In HALTED, a pending instruction SHALL still transfer normally; afterwards instr_valid=0.
REQ-027 PC wrap SHALL be silent; for example, PC 16'hFFFE with len 3 gives next PC 16'h0001.
REQ-028 fetch_count SHALL increment by 1 per transfer and wrap modulo 2^32.

Reset
REQ-029 When rst=0 at an edge, the following SHALL be set and redirect_valid SHALL be ignored:
- PC=RESET_PC, state=RUN;
- instr_valid=0, instr_w0..3=0, instr_len=1, instr_pc=0;
- halted=0, fetch_count=0.
REQ-030 Reset mid-stall or while HALTED SHALL discard the held instruction with no transfer counted.
REQ-031 The first load after reset SHALL occur on the first edge with rst=1.

Structure
REQ-032 A shared package tc_fetch_pkg SHALL hold the state enum (RUN, HALTED), the LEN_MSB/LEN_LSB field positions (15/14), and the default HALT_WORD.
REQ-033 One sub-module, tc_fetch_outreg, SHALL hold the output register plus valid and implement the hold/load rule; the PC, FSM and counter stay in the top level.

Verification
REQ-034 Reset, then memory with len-1 words at 0..3 and instr_ready=1 -> instr_pc sequence 0,1,2,3 on consecutive cycles, and fetch_count=4.
REQ-035 Word 0x8000 (len 3) at address 0x10 -> instr_len=3, instr_pc=0x10, next instr_pc=0x13.
REQ-036 Hold instr_ready=0 for 5 cycles -> instr_valid and all outputs stable, prog_addr unchanged, fetch_count unchanged.
REQ-037 redirect_valid=1, redirect_pc=0x0200 concurrent with a transfer -> fetch_count+1, instr_valid=0 next cycle, then instr_pc=0x0200.
REQ-038 HALT_WORD at 0x20 -> instr_pc=0x20 delivered, halted=1, no further instr_valid; redirect to 0x0 -> halted=0, fetch resumes at 0x0.
REQ-039 PC=0xFFFE with len-3 word, then rst=0 while instr_ready=0 -> next PC 0x0001 observed; after reset all outputs at reset values and fetch_count=0.

Source files
------------

// File: rtl/tc_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, length field
// position and the default halt opcode.
package tc_fetch_pkg;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    localparam int LEN_MSB = 15;
    localparam int LEN_LSB = 14;

    localparam logic [15:0] DEF_HALT_WORD = 16'hFFFF;

    // Length field encodes words-minus-one, so 2'b00 is a single-word instruction.
    function automatic logic [2:0] decode_len(input logic [1:0] i_field);
        return {1'b0, i_field} + 3'd1;
    endfunction

endpackage

// File: rtl/tc_fetch_if.sv
// Fetch-to-decode handshake: the fetch unit holds an instruction, decode
// accepts it by asserting instr_ready while instr_valid is high.
interface tc_fetch_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [WORD_WIDTH-1:0] instr_w0;
    logic [WORD_WIDTH-1:0] instr_w1;
    logic [WORD_WIDTH-1:0] instr_w2;
    logic [WORD_WIDTH-1:0] instr_w3;
    logic [2:0]            instr_len;
    logic [15:0]           instr_pc;

    modport master (
        output instr_valid, instr_w0, instr_w1, instr_w2, instr_w3, instr_len, instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_w0, instr_w1, instr_w2, instr_w3, instr_len, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/tc_fetch_outreg.sv
// Output holding register for the fetched instruction. Data only changes on a
// load, so a stalled decode always sees stable words.
module tc_fetch_outreg
    import tc_fetch_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic                  i_xfer,
    input  logic [WORD_WIDTH-1:0] i_w0,
    input  logic [WORD_WIDTH-1:0] i_w1,
    input  logic [WORD_WIDTH-1:0] i_w2,
    input  logic [WORD_WIDTH-1:0] i_w3,
    input  logic [2:0]            i_len,
    input  logic [15:0]           i_pc,
    output logic                  o_valid,
    output logic [WORD_WIDTH-1:0] o_w0,
    output logic [WORD_WIDTH-1:0] o_w1,
    output logic [WORD_WIDTH-1:0] o_w2,
    output logic [WORD_WIDTH-1:0] o_w3,
    output logic [2:0]            o_len,
    output logic [15:0]           o_pc
);
    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_w0, r_w1, r_w2, r_w3;
    logic [2:0]            r_len;
    logic [15:0]           r_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_len   <= 3'd1;
            r_pc    <= 16'h0000;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_w0    <= i_w0;
            r_w1    <= i_w1;
            r_w2    <= i_w2;
            r_w3    <= i_w3;
            r_len   <= i_len;
            r_pc    <= i_pc;
        end else if (i_xfer) begin
            // Accepted with nothing behind it (halted): drop valid, keep data.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_w0    = r_w0;
    assign o_w1    = r_w1;
    assign o_w2    = r_w2;
    assign o_w3    = r_w3;
    assign o_len   = r_len;
    assign o_pc    = r_pc;
endmodule

// File: rtl/tc_fetch_unit.sv
// Variable-length instruction fetch: PC, RUN/HALTED FSM and accepted-instruction
// counter, feeding decode through a single holding register.
module tc_fetch_unit
    import tc_fetch_pkg::*;
#(
    parameter int          WORD_WIDTH = 16,
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] HALT_WORD  = DEF_HALT_WORD
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [15:0]           prog_addr,
    input  logic [WORD_WIDTH-1:0] prog_w0,
    input  logic [WORD_WIDTH-1:0] prog_w1,
    input  logic [WORD_WIDTH-1:0] prog_w2,
    input  logic [WORD_WIDTH-1:0] prog_w3,
    input  logic                  redirect_valid,
    input  logic [15:0]           redirect_pc,
    tc_fetch_if.master            dec,
    output logic                  halted,
    output logic [31:0]           fetch_count
);
    localparam logic [0:0] ST_RUN    = RUN;
    localparam logic [0:0] ST_HALTED = HALTED;

    logic [0:0]  r_state;
    logic [15:0] r_pc;
    logic [31:0] r_count;
    logic        w_xfer;
    logic        w_load;
    logic        w_is_halt;
    logic [2:0]  w_len;

    assign w_len     = decode_len(prog_w0[LEN_MSB:LEN_LSB]);
    assign w_is_halt = (prog_w0[15:0] == HALT_WORD);
    assign w_xfer    = dec.instr_valid & dec.instr_ready;
    assign w_load    = (r_state == ST_RUN) && !redirect_valid && (!dec.instr_valid || w_xfer);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_count <= 32'd0;
        end else begin
            // A transfer in the redirect cycle still counts; the flush only drops what follows.
            if (w_xfer)
                r_count <= r_count + 32'd1;
            if (redirect_valid) begin
                r_state <= ST_RUN;
                r_pc    <= redirect_pc;
            end else if (w_load) begin
                r_pc <= r_pc + {13'd0, w_len};
                if (w_is_halt)
                    r_state <= ST_HALTED;
            end
        end
    end

    tc_fetch_outreg #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flush (redirect_valid),
        .i_xfer  (w_xfer),
        .i_w0    (prog_w0),
        .i_w1    (prog_w1),
        .i_w2    (prog_w2),
        .i_w3    (prog_w3),
        .i_len   (w_len),
        .i_pc    (r_pc),
        .o_valid (dec.instr_valid),
        .o_w0    (dec.instr_w0),
        .o_w1    (dec.instr_w1),
        .o_w2    (dec.instr_w2),
        .o_w3    (dec.instr_w3),
        .o_len   (dec.instr_len),
        .o_pc    (dec.instr_pc)
    );

    assign prog_addr   = r_pc;
    assign halted      = (r_state == ST_HALTED);
    assign fetch_count = r_count;
endmodule

// File: tb/tb_tc_fetch_unit.sv
// Directed bench for tc_fetch_unit: expected transfers go into a queue, a
// negedge monitor pops and compares every accepted instruction.
module tb_tc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prog_addr;
    logic [15:0] prog_w0, prog_w1, prog_w2, prog_w3;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [31:0] fetch_count;

    logic [15:0] mem [0:65535];
    wire  [15:0] w_a1 = prog_addr + 16'd1;
    wire  [15:0] w_a2 = prog_addr + 16'd2;
    wire  [15:0] w_a3 = prog_addr + 16'd3;
    assign prog_w0 = mem[prog_addr];
    assign prog_w1 = mem[w_a1];
    assign prog_w2 = mem[w_a2];
    assign prog_w3 = mem[w_a3];

    tc_fetch_if #(.WORD_WIDTH(16)) dec ();

    tc_fetch_unit #(
        .WORD_WIDTH (16),
        .RESET_PC   (16'h0000),
        .HALT_WORD  (16'hFFFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .prog_addr      (prog_addr),
        .prog_w0        (prog_w0),
        .prog_w1        (prog_w1),
        .prog_w2        (prog_w2),
        .prog_w3        (prog_w3),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec            (dec),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w0;
        logic [2:0]  len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc, input logic [15:0] w0, input logic [2:0] len);
        exp_t e;
        e.pc = pc; e.w0 = w0; e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer seen at negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst && dec.instr_valid && dec.instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer_pc", {16'h0, dec.instr_pc}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_pc",  {16'h0, dec.instr_pc}, {16'h0, e.pc});
                chk("xfer_w0",  {16'h0, dec.instr_w0}, {16'h0, e.w0});
                chk("xfer_len", {29'h0, dec.instr_len}, {29'h0, e.len});
            end
        end
    end

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        chk({tag, "_valid"},  {31'h0, dec.instr_valid}, 32'd0);
        chk({tag, "_w0"},     {16'h0, dec.instr_w0}, 32'd0);
        chk({tag, "_w1"},     {16'h0, dec.instr_w1}, 32'd0);
        chk({tag, "_w2"},     {16'h0, dec.instr_w2}, 32'd0);
        chk({tag, "_w3"},     {16'h0, dec.instr_w3}, 32'd0);
        chk({tag, "_len"},    {29'h0, dec.instr_len}, 32'd1);
        chk({tag, "_pc"},     {16'h0, dec.instr_pc}, 32'd0);
        chk({tag, "_halted"}, {31'h0, halted}, 32'd0);
        chk({tag, "_count"},  fetch_count, 32'd0);
        chk({tag, "_addr"},   {16'h0, prog_addr}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0010] = 16'h8000;
        mem[16'h0020] = 16'hFFFF;
        mem[16'hFFFE] = 16'h8000;

        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; dec.instr_ready = 1'b0;
        tick(); tick();
        check_reset_values("reset");

        // Sequential single-word instructions at 0..3
        push(16'h0000, 16'h0000, 3'd1);
        push(16'h0001, 16'h0000, 3'd1);
        push(16'h0002, 16'h0000, 3'd1);
        push(16'h0003, 16'h0000, 3'd1);
        tick();
        rst = 1'b1; dec.instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        dec.instr_ready = 1'b0;
        @(negedge clk);
        chk("seq_count", fetch_count, 32'd4);
        chk("seq_held_pc", {16'h0, dec.instr_pc}, 32'h4);

        // Stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("stall_valid", {31'h0, dec.instr_valid}, 32'd1);
            chk("stall_pc",    {16'h0, dec.instr_pc}, 32'h4);
            chk("stall_len",   {29'h0, dec.instr_len}, 32'd1);
            chk("stall_addr",  {16'h0, prog_addr}, 32'h5);
            chk("stall_count", fetch_count, 32'd4);
        end

        // Three-word instruction at 0x10, then redirect concurrent with a transfer
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0; dec.instr_ready = 1'b1;
        @(negedge clk);
        chk("redir_flush_valid", {31'h0, dec.instr_valid}, 32'd0);
        chk("redir_addr", {16'h0, prog_addr}, 32'h10);
        push(16'h0010, 16'h8000, 3'd3);
        push(16'h0013, 16'h0000, 3'd1);
        push(16'h0014, 16'h0000, 3'd1);
        tick();
        @(negedge clk);
        chk("len3_len", {29'h0, dec.instr_len}, 32'd3);
        chk("len3_next_addr", {16'h0, prog_addr}, 32'h13);
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect_valid = 1'b0; dec.instr_ready = 1'b0;
        @(negedge clk);
        chk("xfer_redir_valid", {31'h0, dec.instr_valid}, 32'd0);
        chk("xfer_redir_count", fetch_count, 32'd7);
        chk("xfer_redir_addr", {16'h0, prog_addr}, 32'h200);
        tick();
        @(negedge clk);
        chk("after_redir_valid", {31'h0, dec.instr_valid}, 32'd1);
        chk("after_redir_pc", {16'h0, dec.instr_pc}, 32'h200);

        // Halt word at 0x20
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'h001E;
        tick();
        redirect_valid = 1'b0; dec.instr_ready = 1'b1;
        push(16'h001E, 16'h0000, 3'd1);
        push(16'h001F, 16'h0000, 3'd1);
        push(16'h0020, 16'hFFFF, 3'd4);
        tick(); tick(); tick();
        @(negedge clk);
        chk("halt_enter", {31'h0, halted}, 32'd1);
        chk("halt_presented", {16'h0, dec.instr_pc}, 32'h20);
        tick();
        @(negedge clk);
        chk("halt_drained_valid", {31'h0, dec.instr_valid}, 32'd0);
        chk("halt_count", fetch_count, 32'd10);
        chk("halt_addr", {16'h0, prog_addr}, 32'h24);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("halted_no_valid", {31'h0, dec.instr_valid}, 32'd0);
            chk("halted_stays", {31'h0, halted}, 32'd1);
        end
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("unhalt", {31'h0, halted}, 32'd0);
        chk("unhalt_addr", {16'h0, prog_addr}, 32'h0);
        push(16'h0000, 16'h0000, 3'd1);
        tick(); tick();
        dec.instr_ready = 1'b0;
        @(negedge clk);
        chk("resume_pc", {16'h0, dec.instr_pc}, 32'h1);
        chk("resume_count", fetch_count, 32'd11);

        // PC wrap, then reset while stalled with a redirect that must be ignored
        tick();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("wrap_addr", {16'h0, prog_addr}, 32'h0001);
        chk("wrap_pc", {16'h0, dec.instr_pc}, 32'hFFFE);
        chk("wrap_len", {29'h0, dec.instr_len}, 32'd3);
        tick();
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0055;
        tick();
        check_reset_values("midstall_reset");
        tick();
        rst = 1'b1; redirect_valid = 1'b0; dec.instr_ready = 1'b1;
        push(16'h0000, 16'h0000, 3'd1);
        tick();
        @(negedge clk);
        chk("first_load_valid", {31'h0, dec.instr_valid}, 32'd1);
        chk("first_load_pc", {16'h0, dec.instr_pc}, 32'h0);
        tick();
        dec.instr_ready = 1'b0;
        @(negedge clk);
        chk("post_reset_count", fetch_count, 32'd1);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
